// File: rtl/mem_initiator.sv
// Bus-master front end for the 16-bit magic-memory port.
// Optional access timeout: define MEM_INITIATOR_TIMEOUT_EN.
module mem_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0] state;
  logic       accept;
  logic       access;
  logic       to_hit;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_ready && req_valid;
  assign access    = (state == S_ACCESS);

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;

  // Abort on the edge that would complete the last idle cycle.
  assign to_hit  = access && !mem_resp
                && (to_cnt == TO_LAST);
  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept)
        to_cnt <= '0;
      else if (access && !mem_resp)
        to_cnt <= to_cnt + 1'b1;
      if (to_hit)
        err_q <= 1'b1;
      else if (rsp_valid && rsp_ready)
        err_q <= 1'b0;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= 2'b00;
      mem_address     <= 16'h0000;
      mem_wdata       <= 16'h0000;
      rsp_rdata       <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_read        <= !req_write;
            mem_write       <= req_write;
            mem_byte_enable <= req_be;
            mem_address     <= req_addr;
            mem_wdata       <= req_wdata;
            state           <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_resp) begin
            rsp_rdata <= mem_read ? mem_rdata
                                  : 16'h0000;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= S_RESP;
          end else if (to_hit) begin
            rsp_rdata <= 16'h0000;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready)
            state <= S_IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator against a
// word-array memory model and per-request expectations.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_be;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Responder: answers after wait_cfg strobe cycles.
  logic [15:0] bus_mem [256];
  logic [15:0] ref_mem [256];
  int          wait_cfg = 0;
  logic        resp_en = 1'b1;
  int          hi_cnt;
  logic        strobe;

  assign strobe    = mem_read || mem_write;
  assign mem_resp  = resp_en && strobe
                  && (hi_cnt >= wait_cfg);
  assign mem_rdata = bus_mem[mem_address[8:1]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_cnt <= 0;
    else if (strobe) hi_cnt <= hi_cnt + 1;
    else hi_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mem_write && mem_resp) begin
      if (mem_byte_enable[1])
        bus_mem[mem_address[8:1]][15:8] <= mem_wdata[15:8];
      if (mem_byte_enable[0])
        bus_mem[mem_address[8:1]][7:0] <= mem_wdata[7:0];
    end
  end

  // Strobe-low gap between accesses.
  int   low_run = 0;
  logic prev_hi = 1'b0;
  logic armed = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 0;
      prev_hi = 1'b0;
      armed   = 1'b0;
    end else begin
      if (strobe && !prev_hi && armed)
        check("gap", 32'(low_run >= 2), 1);
      if (strobe) low_run = 0;
      else begin
        low_run++;
        if (prev_hi) armed = 1'b1;
      end
      prev_hi = strobe;
    end
  end

  function automatic logic [15:0] merge(
      input logic [15:0] old_v, input logic [15:0] w,
      input logic [1:0] be);
    merge = old_v;
    if (be[1]) merge[15:8] = w[15:8];
    if (be[0]) merge[7:0]  = w[7:0];
  endfunction

  task automatic wait_rsp(input logic [15:0] exp,
                          input logic err,
                          input int hold,
                          output int lat);
    int k = 0;
    while (!rsp_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    check("rsp_seen", 32'(rsp_valid), 1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    check("rsp_err", 32'(rsp_err), 32'(err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_rdata", 32'(rsp_rdata), 32'(exp));
      check("hold_rdy", 32'(req_ready), 0);
      check("hold_strb", 32'(strobe), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_fall", 32'(rsp_valid), 0);
    check("idle_rdy", 32'(req_ready), 1);
  endtask

  task automatic txn(input logic wr, input logic [1:0] be,
                     input logic [15:0] addr,
                     input logic [15:0] wd,
                     input int waits, input int hold);
    logic [15:0] exp;
    int n = 0;
    int lat;
    int idx = int'(addr[8:1]);
    if (wr) begin
      ref_mem[idx] = merge(ref_mem[idx], wd, be);
      exp = 16'h0000;
    end else exp = ref_mem[idx];
    wait_cfg = waits;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_be = be;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = !wr;
    req_be    = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    while (strobe && n < 300) begin
      if (mem_address !== addr || mem_byte_enable !== be
          || mem_write !== wr || mem_read !== !wr
          || (wr && mem_wdata !== wd))
        check("bus_fields",
              {mem_address, 14'd0, mem_byte_enable},
              {addr, 14'd0, be});
      n++;
      @(negedge clk);
    end
    check("strobe_len", 32'(n), 32'(waits + 1));
    wait_rsp(exp, 1'b0, hold, lat);
    check("rsp_latency", 32'(lat), 0);
  endtask

  initial begin
    int lat;
    int n;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
    end
    bus_mem[8] = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_be = 2'b00; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(req_ready), 1);
    check("rst_outs", {15'd0, rsp_valid, rsp_rdata},
          32'h0);
    check("rst_bus", {mem_address, mem_wdata}, 32'h0);
    rst_n = 1'b1;

    txn(1'b0, 2'b11, 16'h0010, 16'h0000, 0, 0);
    txn(1'b1, 2'b01, 16'h0021, 16'h1234, 0, 0);
    check("wr_mem", 32'(bus_mem[16]),
          32'(ref_mem[16]));
    txn(1'b0, 2'b01, 16'h0020, 16'h0000, 0, 1);
    txn(1'b0, 2'b10, 16'h0010, 16'h0000, 4, 0);
    txn(1'b1, 2'b00, 16'h0030, 16'hFFFF, 2, 0);

    // Back-to-back with response backpressure.
    wait_cfg = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_be = 2'b11;
    req_addr = 16'h0040; req_wdata = 16'h0;
    @(negedge clk);
    check("b2b_strb", 32'(mem_read), 1);
    check("b2b_rdy", 32'(req_ready), 0);
    req_write = 1'b1; req_be = 2'b10;
    req_addr = 16'h0042; req_wdata = 16'hC3D4;
    @(negedge clk);
    wait_rsp(ref_mem[32], 1'b0, 5, lat);
    ref_mem[33] = merge(ref_mem[33], 16'hC3D4, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_wr", {mem_write, mem_address},
          {16'd1, 16'h0042});
    wait_rsp(16'h0000, 1'b0, 0, lat);
    txn(1'b0, 2'b11, 16'h0042, 16'h0, 0, 0);

    for (int t = 0; t < 40; t++)
      txn(1'($urandom), 2'($urandom),
          16'($urandom_range(0, 511)),
          16'($urandom), $urandom_range(0, 5),
          $urandom_range(0, 3));

    // Async reset mid-access.
    resp_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_be = 2'b11;
    req_addr = 16'h0050;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_rd", 32'(mem_read), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_rd", 32'(mem_read), 0);
    check("rst_async_rdy", 32'(req_ready), 1);
    check("rst_async_out", {mem_address, rsp_rdata},
          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || strobe) n++;
    end
    check("no_rsp_after_rst", 32'(n), 0);

    // Stuck responder.
    resp_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_be = 2'b11;
    req_addr = 16'h0060; req_wdata = 16'h5555;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
    while (mem_write && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("to_len", 32'(n), 8);
    resp_en = 1'b1;
    wait_rsp(16'h0000, 1'b1, 2, lat);
    check("to_lat", 32'(lat), 0);
    txn(1'b0, 2'b11, 16'h0060, 16'h0, 0, 0);
`else
    repeat (100) begin
      if (mem_write && !rsp_valid) n++;
      @(negedge clk);
    end
    check("stuck_len", 32'(n), 100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus-master front end for the 16-bit magic-memory port: the requesting side of the read/write/byte_enable/address/wdata/resp/rdata interface.
- Accepts one request from a client (CPU datapath or test driver) over a valid/ready handshake.
- Drives the level-sensitive memory strobes, waits for resp, and returns read data or completion over a valid/ready response channel.
- Guarantees a strobe-low gap between transactions, so an edge-triggered responder sees a fresh rising edge per access.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in ACCESS without mem_resp before abort (used only with the optional feature); width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  client request present
- req_ready  out  1  initiator can accept request
- req_write  in  1  1 = write, 0 = read
- req_be  in  2  byte enables, [1] high byte, [0] low byte
- req_addr  in  16  byte address, passed through unmodified
- req_wdata  in  16  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  client accepts response
- rsp_rdata  out  16  read data (0x0000 for writes)
- rsp_err  out  1  transaction aborted by timeout
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_byte_enable  out  2  to memory
- mem_address  out  16  to memory
- mem_wdata  out  16  to memory
- mem_resp  in  1  memory response, may be combinational from strobes
- mem_rdata  in  16  memory read data, valid while mem_resp high on a read

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 except req_ready = 1. mem_read and mem_write fall immediately, with no clock needed. An in-flight transaction is dropped with no response.
- IDLE:
  - req_ready = 1, strobes low, rsp_valid = 0.
  - On req_valid && req_ready: register write, be, addr and wdata into mem_* output registers; go to ACCESS.
- ACCESS:
  - req_ready = 0.
  - Exactly one of mem_read / mem_write is high (per latched req_write); the other stays 0.
  - mem_address, mem_byte_enable and mem_wdata are held stable for the whole state.
  - On a clock edge with mem_resp = 1:
    - read: latch mem_rdata into rsp_rdata;
    - write: set rsp_rdata = 0x0000;
    - in both cases drop the strobe and go to RESP.
  - If mem_resp = 0, stay in ACCESS indefinitely (unless the timeout feature is enabled).
- RESP:
  - Strobes low; rsp_valid = 1; rsp_rdata and rsp_err held stable.
  - On rsp_ready: go to IDLE; rsp_valid falls next cycle.
  - mem_resp is ignored in RESP.
- Latency with a zero-wait responder:
  - accept at edge 0;
  - strobe high during cycle 1;
  - rsp_valid during cycle 2;
  - with rsp_ready = 1, IDLE in cycle 3.
  - Minimum 3 cycles per transaction; strobes low for at least 2 cycles between accesses.
- Request fields are sampled only at the accept edge; later changes to req_* have no effect.
- Byte enables are forwarded on reads as given. rsp_rdata always carries the full 16 bits.
- Write with req_be = 2'b00 is still issued as a normal bus cycle.
- mem_* outputs are driven only from registers; no input-to-output combinational path.
- mem_address, mem_byte_enable and mem_wdata retain their last values after a transaction. Consumers must qualify them with the strobes.

Optional Feature:
- Macro MEM_INITIATOR_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle with mem_resp = 0.
  - On reaching TIMEOUT_CYCLES: drop the strobe, set rsp_err = 1 and rsp_rdata = 0x0000, go to RESP.
  - rsp_err clears on return to IDLE.
  - A late mem_resp after abort is ignored.
- Undefined: no counter; ACCESS waits forever; rsp_err is tied to 0.

Test Plan:
- Reset: assert rst_n = 0 mid-ACCESS with mem_read high -> mem_read falls within the same cycle; req_ready = 1, rsp_valid = 0, all other outputs 0; no response after release.
- Read: req addr 0x0010, be 2'b11, memory returns 0xBEEF with zero wait -> mem_read high exactly 1 cycle, mem_address 0x0010; rsp_valid the next cycle with rsp_rdata 0xBEEF, rsp_err 0.
- Write: addr 0x0021, be 2'b01, wdata 0x1234 -> mem_write high 1 cycle, mem_address 0x0021, mem_byte_enable 2'b01, mem_wdata 0x1234, mem_read stays 0; rsp_rdata 0x0000.
- Backpressure and back-to-back: two requests with req_valid held high, rsp_ready low for 5 cycles -> rsp_valid and data stable, req_ready 0; after release, second strobe preceded by at least 2 low cycles.
- Wait states: mem_resp delayed 4 cycles -> strobe high 5 cycles with address/data stable; rsp_rdata equals mem_rdata at the resp edge.
- Timeout (macro on, TIMEOUT_CYCLES = 8, mem_resp stuck 0) -> strobe drops after 8 ACCESS cycles; rsp_valid with rsp_err 1 and rsp_rdata 0x0000. Macro off: strobe held for 100 cycles, no response.
